// File: rtl/a2d_pkg.sv
// -----------------------------------------------------------------------------
// a2d_pkg
// Shared definitions for the A2D conversion sequencer:
//   state_t    - sequencer states
//   ch_idx_t   - 2-bit round position (0 = left, 1 = right, 2 = battery)
//   DEF_CH_*   - default A2D channel numbers
//   DEF_TMO_W  - default width of the SPI frame timeout counter
//   cmd_frame  - builds the command frame that selects an A2D channel
// -----------------------------------------------------------------------------
package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WT_CMD,
      GAP,
      RD,
      WT_RD,
      DONE
   } state_t;

   typedef logic [1:0] ch_idx_t;

   localparam ch_idx_t IDX_LFT  = 2'd0;
   localparam ch_idx_t IDX_RGHT = 2'd1;
   localparam ch_idx_t IDX_BATT = 2'd2;

   localparam logic [2:0] DEF_CH_LFT  = 3'd0;
   localparam logic [2:0] DEF_CH_RGHT = 3'd4;
   localparam logic [2:0] DEF_CH_BATT = 3'd5;

   localparam int DEF_TMO_W = 10;

   // Channel number sits in bits [13:11]; everything else is zero.
   function automatic logic [15:0] cmd_frame(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/a2d_sched_if.sv
// -----------------------------------------------------------------------------
// a2d_sched_if
// Handshake between the conversion sequencer and the SPI master.
//   spi_wrt   - one-cycle frame start (sequencer -> SPI master)
//   spi_cmd   - frame to transmit, stable from spi_wrt until spi_done
//   spi_done  - one-cycle frame complete (SPI master -> sequencer)
//   spi_rd    - received frame, valid with spi_done
// Modports: master = sequencer side, slave = SPI master side.
// -----------------------------------------------------------------------------
interface a2d_sched_if;

   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_rd;

   modport master (
      output spi_wrt,
      output spi_cmd,
      input  spi_done,
      input  spi_rd
   );

   modport slave (
      input  spi_wrt,
      input  spi_cmd,
      output spi_done,
      output spi_rd
   );

endinterface

// File: rtl/a2d_tmo_cnt.sv
// -----------------------------------------------------------------------------
// a2d_tmo_cnt
// Clear/enable counter that stops at all-ones and flags it.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - synchronous clear (wins over en)
//   en       - count one per cycle while not saturated
//   sat      - counter is all-ones
// -----------------------------------------------------------------------------
module a2d_tmo_cnt #(
   parameter int W = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic sat
);

   logic [W-1:0] cnt;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge value of its inputs regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = &cnt;

endmodule

// File: rtl/a2d_sched.sv
// -----------------------------------------------------------------------------
// a2d_sched
// Runs one A2D conversion round per nxt request: left load cell, right load
// cell, battery. Each channel takes a command frame (reply discarded), one
// idle GAP cycle, then a read frame whose low 12 bits are the result.
//   clk, rst  - clock, asynchronous active-high reset
//   nxt       - one-cycle round request (ignored while busy)
//   spi       - SPI master handshake (master modport)
//   lft_ld    - latest left load result
//   rght_ld   - latest right load result
//   batt      - latest battery result
//   rnd_vld   - one-cycle pulse once all three results are updated
//   busy      - round in progress
//   tmo_err   - sticky: an SPI frame timed out (cleared only by rst)
// -----------------------------------------------------------------------------
module a2d_sched
   import a2d_pkg::*;
#(
   parameter logic [2:0] CH_LFT  = DEF_CH_LFT,
   parameter logic [2:0] CH_RGHT = DEF_CH_RGHT,
   parameter logic [2:0] CH_BATT = DEF_CH_BATT,
   parameter int         TMO_W   = DEF_TMO_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               nxt,
   a2d_sched_if.master        spi,
   output logic [11:0]        lft_ld,
   output logic [11:0]        rght_ld,
   output logic [11:0]        batt,
   output logic               rnd_vld,
   output logic               busy,
   output logic               tmo_err
);

   state_t     state, state_nxt;
   ch_idx_t    idx, idx_nxt;
   logic [2:0] ch_sel;
   logic       wrt_set;
   logic       cnt_clr;
   logic       cnt_en;
   logic       cap_en;
   logic       tmo_sat;
   logic       tmo_fire;

   // Upper nibble of the read frame carries no result data.
   logic       unused_rd_hi;
   assign unused_rd_hi = ^spi.spi_rd[15:12];

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= IDX_LFT;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no
      // latch is inferred.
      state_nxt = state;
      idx_nxt   = idx;
      unique case (state)
         IDLE:   if (nxt) state_nxt = CMD;
         CMD:    state_nxt = WT_CMD;
         WT_CMD: begin
            if (spi.spi_done) begin
               state_nxt = GAP;
            end else if (tmo_sat) begin
               state_nxt = IDLE;
               idx_nxt   = IDX_LFT;
            end
         end
         GAP:    state_nxt = RD;
         RD:     state_nxt = WT_RD;
         WT_RD: begin
            // spi_done is tested first so a reply on the saturating cycle
            // still counts as on time.
            if (spi.spi_done) begin
               if (idx == IDX_BATT) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = CMD;
                  idx_nxt   = idx + 2'd1;
               end
            end else if (tmo_sat) begin
               state_nxt = IDLE;
               idx_nxt   = IDX_LFT;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            idx_nxt   = IDX_LFT;
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = IDX_LFT;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------------
   always_comb begin
      busy     = 1'b0;
      rnd_vld  = 1'b0;
      wrt_set  = 1'b0;
      cnt_en   = 1'b0;
      cap_en   = 1'b0;
      tmo_fire = 1'b0;
      busy     = (state != IDLE);
      rnd_vld  = (state == DONE);
      wrt_set  = (state == CMD) || (state == RD);
      cnt_en   = (state == WT_CMD) || (state == WT_RD);
      cap_en   = (state == WT_RD) && spi.spi_done;
      tmo_fire = cnt_en && tmo_sat && !spi.spi_done;
   end

   // Counter restarts on the cycle a frame is launched, so it reads zero on
   // the first wait cycle.
   assign cnt_clr = wrt_set;

   always_comb begin
      unique case (idx)
         IDX_LFT:  ch_sel = CH_LFT;
         IDX_RGHT: ch_sel = CH_RGHT;
         default:  ch_sel = CH_BATT;
      endcase
   end

   a2d_tmo_cnt #(
      .W (TMO_W)
   ) u_tmo_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .sat (tmo_sat)
   );

   // ---------------------------------------------------------------------
   // SPI launch, command hold, result capture and error flag
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spi.spi_wrt <= 1'b0;
         spi.spi_cmd <= 16'h0000;
         lft_ld      <= 12'h000;
         rght_ld     <= 12'h000;
         batt        <= 12'h000;
         tmo_err     <= 1'b0;
      end else begin
         spi.spi_wrt <= wrt_set;
         // Loaded only in CMD; the read frame reuses the same command.
         if (state == CMD) begin
            spi.spi_cmd <= cmd_frame(ch_sel);
         end
         if (cap_en) begin
            unique case (idx)
               IDX_LFT:  lft_ld  <= spi.spi_rd[11:0];
               IDX_RGHT: rght_ld <= spi.spi_rd[11:0];
               default:  batt    <= spi.spi_rd[11:0];
            endcase
         end
         if (tmo_fire) begin
            tmo_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_a2d_sched.sv
// -----------------------------------------------------------------------------
// tb_a2d_sched
// Directed rounds with randomized data/delays against a channel-level model:
// each round is six frames (two per channel 0, 4, 5), results are the low 12
// bits of each read reply, a frame unanswered for 1023 wait cycles sets the
// sticky error and abandons the round.
// -----------------------------------------------------------------------------
module tb_a2d_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        nxt;
   logic [11:0] lft_ld, rght_ld, batt;
   logic        rnd_vld, busy, tmo_err;

   a2d_sched_if spi ();

   a2d_sched dut (
      .clk     (clk),
      .rst     (rst),
      .nxt     (nxt),
      .spi     (spi),
      .lft_ld  (lft_ld),
      .rght_ld (rght_ld),
      .batt    (batt),
      .rnd_vld (rnd_vld),
      .busy    (busy),
      .tmo_err (tmo_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      int          dly;
      bit          drop;
      int          kind;   // 0 = command reply, 1..3 = result for channel slot
   } resp_t;

   resp_t       resp_q[$];
   logic [15:0] cmd_q[$];
   int          vld_cnt  = 0;
   int          vld_base = 0;
   int          wrt_cyc  = 0;
   int          cyc      = 0;
   int          checks   = 0;
   int          failures = 0;

   logic [11:0] m_ld    [3];
   logic [15:0] rd_data [3];
   int          rd_dly  [3];
   int          cmd_dly [3];
   bit          rand_cmd_reply = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int chan_of(input int slot);
      case (slot)
         0:       return 0;
         1:       return 4;
         default: return 5;
      endcase
   endfunction

   function automatic logic [15:0] exp_cmd(input int slot);
      return 16'(chan_of(slot) * 2048);
   endfunction

   function automatic logic [11:0] reg_of(input int slot);
      case (slot)
         0:       return lft_ld;
         1:       return rght_ld;
         default: return batt;
      endcase
   endfunction

   // Frame/pulse monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (spi.spi_wrt === 1'b1) begin
               cmd_q.push_back(spi.spi_cmd);
               wrt_cyc = cyc;
            end
            if (rnd_vld === 1'b1) vld_cnt++;
         end
      end
   end

   // SPI master model: answers each frame after its queued delay
   initial begin
      resp_t r;
      spi.spi_done = 1'b0;
      spi.spi_rd   = 16'h0000;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && spi.spi_wrt === 1'b1) begin
            if (resp_q.size() > 0) r = resp_q.pop_front();
            else                   r = '{16'hFFFF, 2, 1'b0, 0};
            if (!r.drop) begin
               repeat (r.dly) @(negedge clk);
               spi.spi_done = 1'b1;
               spi.spi_rd   = r.data;
               @(negedge clk);
               spi.spi_done = 1'b0;
               spi.spi_rd   = 16'($urandom);
               if (r.kind != 0 && rst === 1'b0)
                  check($sformatf("capture_slot%0d", r.kind - 1), reg_of(r.kind - 1), r.data[11:0]);
            end
         end
      end
   end

   task automatic randomize_round();
      for (int i = 0; i < 3; i++) begin
         rd_data[i] = 16'($urandom);
         rd_dly[i]  = $urandom_range(0, 12);
         cmd_dly[i] = $urandom_range(0, 12);
      end
   endtask

   task automatic queue_round(input bit drop_batt);
      for (int i = 0; i < 3; i++) begin
         resp_q.push_back('{rand_cmd_reply ? 16'($urandom) : 16'hFFFF, cmd_dly[i], 1'b0, 0});
         resp_q.push_back('{rd_data[i], rd_dly[i], (i == 2) && drop_batt, i + 1});
      end
   endtask

   task automatic start_round(input string tag);
      vld_base = vld_cnt;
      @(negedge clk) nxt = 1'b1;
      @(negedge clk) nxt = 1'b0;
      check({tag, "_busy_rise"}, busy, 1);
      @(negedge clk);
      check({tag, "_wrt_latency"}, spi.spi_wrt, 1);
   endtask

   task automatic finish_round(input string tag, input int exp_vld);
      int n = 0;
      while (busy === 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_round_end"}, busy, 0);
      repeat (5) @(negedge clk);
      check({tag, "_frames"}, cmd_q.size(), 6);
      for (int i = 0; i < cmd_q.size() && i < 6; i++)
         check($sformatf("%s_cmd%0d", tag, i), cmd_q[i], exp_cmd(i / 2));
      check({tag, "_rnd_vld"}, vld_cnt - vld_base, exp_vld);
      check({tag, "_lft"},  lft_ld,  m_ld[0]);
      check({tag, "_rght"}, rght_ld, m_ld[1]);
      check({tag, "_batt"}, batt,    m_ld[2]);
   endtask

   task automatic do_round(input string tag);
      cmd_q.delete();
      queue_round(1'b0);
      start_round(tag);
      for (int i = 0; i < 3; i++) m_ld[i] = rd_data[i][11:0];
      finish_round(tag, 1);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      nxt = 1'b0;
      for (int i = 0; i < 3; i++) m_ld[i] = 12'h000;
      repeat (3) @(negedge clk);
      check("rst_lft",  lft_ld,  0);
      check("rst_rght", rght_ld, 0);
      check("rst_batt", batt,    0);
      check("rst_cmd",  spi.spi_cmd, 0);
      check("rst_wrt",  spi.spi_wrt, 0);
      check("rst_vld",  rnd_vld, 0);
      check("rst_busy", busy,    0);
      check("rst_tmo",  tmo_err, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic round with all-ones command replies
      rand_cmd_reply = 1'b0;
      rd_data = '{16'h0ABC, 16'h0123, 16'h0456};
      rd_dly  = '{3, 5, 2};
      cmd_dly = '{1, 4, 0};
      do_round("basic");
      rand_cmd_reply = 1'b1;

      // Upper reply bits must be dropped
      randomize_round();
      rd_data[0] = 16'hF7FF;
      do_round("mask");
      check("mask_value", lft_ld, 12'h7FF);

      for (int r = 0; r < 6; r++) begin
         randomize_round();
         do_round($sformatf("rand%0d", r));
      end

      // Extra nxt while the right read frame is pending
      randomize_round();
      rd_dly[1] = 20;
      cmd_q.delete();
      queue_round(1'b0);
      start_round("busy_nxt");
      n = 0;
      while (cmd_q.size() < 4 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("busy_nxt_reach_rd", cmd_q.size() >= 4, 1);
      @(negedge clk) nxt = 1'b1;
      @(negedge clk) nxt = 1'b0;
      for (int i = 0; i < 3; i++) m_ld[i] = rd_data[i][11:0];
      finish_round("busy_nxt", 1);
      repeat (30) @(negedge clk);
      check("busy_nxt_no_queue_frames", cmd_q.size(), 6);
      check("busy_nxt_idle", busy, 0);

      // Battery read frame never answered
      randomize_round();
      cmd_q.delete();
      queue_round(1'b1);
      start_round("tmo");
      n = 0;
      while (tmo_err !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("tmo_flag", tmo_err, 1);
      check("tmo_latency", cyc - wrt_cyc, 1024);
      check("tmo_busy_low", busy, 0);
      m_ld[0] = rd_data[0][11:0];
      m_ld[1] = rd_data[1][11:0];
      finish_round("tmo", 0);

      randomize_round();
      do_round("after_tmo");
      check("after_tmo_sticky", tmo_err, 1);

      // Reset during the left-channel GAP cycle
      randomize_round();
      cmd_dly[0] = 3;
      cmd_q.delete();
      queue_round(1'b0);
      start_round("midrst");
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         #1;
         if (spi.spi_done === 1'b1) break;
         n++;
      end
      check("midrst_done_seen", spi.spi_done, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_wrt",  spi.spi_wrt, 0);
      check("midrst_cmd",  spi.spi_cmd, 0);
      check("midrst_lft",  lft_ld, 0);
      check("midrst_rght", rght_ld, 0);
      check("midrst_batt", batt, 0);
      check("midrst_tmo",  tmo_err, 0);
      check("midrst_vld",  rnd_vld, 0);
      resp_q.delete();
      for (int i = 0; i < 3; i++) m_ld[i] = 12'h000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      randomize_round();
      do_round("post_rst");

      // Replies arriving exactly on the saturating count
      randomize_round();
      cmd_dly[0] = 1023;
      rd_dly[2]  = 1023;
      do_round("tmo_edge");
      check("tmo_edge_no_err", tmo_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/a2d_sched.md
Name: a2d_sched

Overview:
Sequencer that owns the A2D SPI master and runs one conversion round per request. A round covers three channels in fixed order: left load cell, right load cell, battery. Each channel uses the two-transaction A2D protocol: a command frame selects the channel, and the following frame returns its result. The block sits between the inertial-valid strobe (nxt) and the SPI master, and holds the latest 12-bit results for steer-enable, balance and piezo logic.

Parameters:
CH_LFT, 3'd0, A2D channel number for left load cell
CH_RGHT, 3'd4, A2D channel number for right load cell
CH_BATT, 3'd5, A2D channel number for battery
TMO_W, 10, width of the SPI timeout counter; timeout fires at 2**TMO_W-1 cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
nxt  in  1  one-cycle request to start a conversion round
spi_done  in  1  one-cycle pulse from SPI master: frame complete
spi_rd  in  16  SPI master read data, valid on spi_done
spi_wrt  out  1  one-cycle pulse to SPI master to start a frame
spi_cmd  out  16  frame to transmit; held stable from spi_wrt until spi_done
lft_ld  out  12  latest left load result
rght_ld  out  12  latest right load result
batt  out  12  latest battery result
rnd_vld  out  1  one-cycle pulse: all three results updated this round
busy  out  1  high from round start until return to IDLE
tmo_err  out  1  sticky: an SPI frame exceeded the timeout; cleared only by rst

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - lft_ld, rght_ld, batt = 12'h000
  - spi_cmd = 16'h0000
  - spi_wrt, rnd_vld, busy, tmo_err = 0
  - state = IDLE, channel index = 0
- Command frame: spi_cmd = {2'b00, ch[2:0], 11'h000}, where ch comes from a 2-bit index (0=LFT, 1=RGHT, 2=BATT).
- States:
  - IDLE: on nxt, go to CMD; busy goes high the next cycle. nxt while busy is ignored; it is not queued.
  - CMD: assert spi_wrt for one cycle with the channel command; go to WT_CMD.
  - WT_CMD: wait for spi_done and discard spi_rd; go to GAP.
  - GAP: one idle cycle so SS_n deasserts between frames; go to RD.
  - RD: assert spi_wrt for one cycle. spi_cmd still carries the same channel command; go to WT_RD.
  - WT_RD: on spi_done, capture spi_rd[11:0] into the register for the current channel.
    - If index == 2: go to DONE.
    - Otherwise: increment index, go to CMD.
  - DONE: pulse rnd_vld for one cycle, clear index, go to IDLE; busy falls the same cycle as state = IDLE.
- Result update order: left results register updates before right, and right before battery. Each register changes exactly on the cycle after its spi_done.
- Latency with zero-delay SPI: nxt→first spi_wrt = 2 cycles. Total round = 6 frames + 3 GAP cycles + DONE.
- Timeout:
  - A TMO_W-bit counter clears on entry to WT_CMD/WT_RD and increments each cycle in those states.
  - On reaching all-ones without spi_done: set tmo_err, abandon the round (no rnd_vld, registers keep partially updated values), clear index, return to IDLE.
  - If spi_done arrives on the same cycle the counter saturates, spi_done wins and there is no error.
- spi_done received in IDLE, CMD, GAP or DONE is ignored.
- rst asserted mid-round: immediate return to reset values. The SPI master is reset by the same rst, so no frame is left pending.
- tmo_err does not block later rounds.

Decomposition:
- Shared package a2d_pkg:
  - state enum (IDLE, CMD, WT_CMD, GAP, RD, WT_RD, DONE)
  - channel index typedef (2-bit)
  - command-frame construction function
  - default channel numbers
- One natural sub-module: a2d_tmo_cnt, a parameterized clear/enable timeout counter with a saturate flag.
- The FSM and result registers stay in a2d_sched.

Test Plan:
- Basic round:
  - Stimulus: nxt pulse; SPI model returns 16'h0ABC, 16'h0123, 16'h0456 on the RD frames and 16'hFFFF on CMD frames.
  - Required: lft_ld = 12'hABC, rght_ld = 12'h123, batt = 12'h456; exactly one rnd_vld; six spi_wrt pulses carrying cmds 16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800.
- Upper bits masked:
  - Stimulus: RD frame returns 16'hF7FF.
  - Required: stored result = 12'h7FF.
- nxt while busy:
  - Stimulus: second nxt during WT_RD of the right channel.
  - Required: only six frames total and one rnd_vld; busy stays high continuously.
- Timeout:
  - Stimulus: withhold spi_done on the battery RD frame.
  - Required: tmo_err = 1 after 1023 cycles in WT_RD; no rnd_vld; busy = 0; lft_ld/rght_ld updated, batt unchanged. A subsequent nxt completes a normal round with tmo_err still 1.
- Reset mid-round:
  - Stimulus: assert rst during GAP of the left channel, then release and pulse nxt.
  - Required: all outputs return to reset values asynchronously; the next round starts at channel 0 with cmd 16'h0000.
- Timeout boundary:
  - Stimulus: spi_done coincides with the counter reaching 1023.
  - Required: result captured and tmo_err stays 0.
